// File: rtl/system86_video_timing_pkg.sv
// Shared System86 raster timing constants and types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package system86_video_pkg;

    // Default raster geometry for the 6.144 MHz pixel clock.
    localparam int H_TOTAL   = 384;
    localparam int H_VISIBLE = 288;
    localparam int HS_START  = 312;
    localparam int HS_WIDTH  = 32;
    localparam int V_TOTAL   = 264;
    localparam int V_VISIBLE = 224;
    localparam int VS_START  = 232;
    localparam int VS_WIDTH  = 8;
    localparam int VINT_LINE = 224;

    // Raster coordinate shared with the tile, sprite and colour stages.
    typedef logic [8:0] coord_t;

    // Every decoded per-pixel timing output, registered as one word.
    typedef struct packed {
        logic clk_2h;
        logic latch0;
        logic latch1;
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
        logic vint;
    } vid_dec_t;

endpackage

// File: rtl/system86_video_timing_if.sv
// Raster timing bundle: counters plus decoded strobes/sync/blanking.
// Latency: n/a (wires only).
// Backpressure: none; the raster never stalls.
interface system86_video_timing_if;
    import system86_video_pkg::*;

    coord_t H;
    coord_t V;
    logic   CLK_2H;
    logic   LATCH0;
    logic   LATCH1;
    logic   HBLANK;
    logic   VBLANK;
    logic   HSYNC;
    logic   VSYNC;
    logic   VINT;

    // Timing generator drives the bundle.
    modport master (
        output H, V, CLK_2H, LATCH0, LATCH1, HBLANK, VBLANK, HSYNC, VSYNC, VINT
    );

    // Tile/sprite/colour stages consume it.
    modport slave (
        input  H, V, CLK_2H, LATCH0, LATCH1, HBLANK, VBLANK, HSYNC, VSYNC, VINT
    );
endinterface

// File: rtl/system86_video_timing_wrap_counter.sv
// Modulo-MODULUS counter with advance enable, terminal count and next-value view.
// Latency: count updates one cycle after en_i; nxt_o is the value it will take.
// Backpressure: none; en_i low simply holds the count.
module system86_wrap_counter
    import system86_video_pkg::*;
#(
    parameter int MODULUS = 384
) (
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   en_i,
    output coord_t cnt_o,
    output coord_t nxt_o,
    output logic   tc_o
);

    coord_t cnt_q;
    coord_t cnt_d;

    // Next count: wrap to zero after the last value, otherwise step when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + coord_t'(1);
        end
    end

    // Count register, synchronously cleared.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o  = (cnt_q == coord_t'(MODULUS - 1));
    assign cnt_o = cnt_q;
    assign nxt_o = cnt_d;

endmodule

// File: rtl/system86_video_timing.sv
// System86 raster timing: H/V counters, sync, blanking, CLK_2H, LATCH0/1 and VINT.
// Latency: all decodes are registered from next-state counters, so they align with H/V.
// Backpressure: none; the raster advances every CLK_6M cycle.
module system86_video_timing
    import system86_video_pkg::*;
#(
    parameter int H_TOTAL_P   = H_TOTAL,
    parameter int H_VISIBLE_P = H_VISIBLE,
    parameter int HS_START_P  = HS_START,
    parameter int HS_WIDTH_P  = HS_WIDTH,
    parameter int V_TOTAL_P   = V_TOTAL,
    parameter int V_VISIBLE_P = V_VISIBLE,
    parameter int VS_START_P  = VS_START,
    parameter int VS_WIDTH_P  = VS_WIDTH,
    parameter int VINT_LINE_P = VINT_LINE
) (
    input  logic                    CLK_6M,
    input  logic                    RST_N,
    system86_video_timing_if.master vid
);

    // Illegal geometry is caught at elaboration rather than as a broken raster.
    if (HS_START_P + HS_WIDTH_P > H_TOTAL_P) begin : g_bad_hsync
        $error("HSYNC extends past end of line");
    end
    if (VS_START_P + VS_WIDTH_P > V_TOTAL_P) begin : g_bad_vsync
        $error("VSYNC extends past end of frame");
    end
    if (VINT_LINE_P >= V_TOTAL_P) begin : g_bad_vint
        $error("VINT line outside frame");
    end
    if (H_TOTAL_P > 512 || V_TOTAL_P > 512) begin : g_bad_total
        $error("raster totals exceed 9-bit coordinate");
    end

    coord_t   h_q, h_d, v_q, v_d;
    logic     h_tc, v_tc;
    vid_dec_t dec_q, dec_d;

    system86_wrap_counter #(.MODULUS(H_TOTAL_P)) u_hcnt (
        .clk_i   (CLK_6M),
        .rst_n_i (RST_N),
        .en_i    (1'b1),
        .cnt_o   (h_q),
        .nxt_o   (h_d),
        .tc_o    (h_tc)
    );

    // V only steps on the cycle H wraps.
    system86_wrap_counter #(.MODULUS(V_TOTAL_P)) u_vcnt (
        .clk_i   (CLK_6M),
        .rst_n_i (RST_N),
        .en_i    (h_tc),
        .cnt_o   (v_q),
        .nxt_o   (v_d),
        .tc_o    (v_tc)
    );

    // Pure decode of one raster position into its timing outputs.
    function automatic vid_dec_t decode(input coord_t h, input coord_t v);
        vid_dec_t d;
        d.clk_2h = h[1];
        d.latch0 = (h[2:0] == 3'd3);
        d.latch1 = (h[2:0] == 3'd7);
        d.hblank = (int'(h) >= H_VISIBLE_P);
        d.vblank = (int'(v) >= V_VISIBLE_P);
        d.hsync  = (int'(h) >= HS_START_P) && (int'(h) < HS_START_P + HS_WIDTH_P);
        d.vsync  = (int'(v) >= VS_START_P) && (int'(v) < VS_START_P + VS_WIDTH_P);
        d.vint   = (h == '0) && (int'(v) == VINT_LINE_P);
        return d;
    endfunction

    // Decode the position the counters are about to hold; reset forces (0,0).
    always_comb begin
        dec_d = decode(h_d, v_d);
        if (!RST_N) begin
            dec_d = decode('0, '0);
        end
    end

    // Output register, updated alongside the counters so there is no decode lag.
    always_ff @(posedge CLK_6M) begin
        dec_q <= dec_d;
    end

    assign vid.H      = h_q;
    assign vid.V      = v_q;
    assign vid.CLK_2H = dec_q.clk_2h;
    assign vid.LATCH0 = dec_q.latch0;
    assign vid.LATCH1 = dec_q.latch1;
    assign vid.HBLANK = dec_q.hblank;
    assign vid.VBLANK = dec_q.vblank;
    assign vid.HSYNC  = dec_q.hsync;
    assign vid.VSYNC  = dec_q.vsync;
    assign vid.VINT   = dec_q.vint;

    // The frame terminal count is available for future frame-rate logic.
    logic frame_tc_unused;
    assign frame_tc_unused = v_tc & h_tc;

endmodule

// File: tb/tb_system86_video_timing.sv
// Self-checking bench for system86_video_timing against a frame-position model.
// A shortened frame (full-width lines, fewer lines) keeps the run brief.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_system86_video_timing;

    localparam int HT  = 384;
    localparam int HV  = 288;
    localparam int HSS = 312;
    localparam int HSW = 32;
    localparam int VT  = 40;
    localparam int VV  = 24;
    localparam int VSS = 30;
    localparam int VSW = 4;
    localparam int VIL = 24;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int pos = 0;   // model: cycles since frame start

    system86_video_timing_if vif();

    system86_video_timing #(
        .H_TOTAL_P(HT), .H_VISIBLE_P(HV), .HS_START_P(HSS), .HS_WIDTH_P(HSW),
        .V_TOTAL_P(VT), .V_VISIBLE_P(VV), .VS_START_P(VSS), .VS_WIDTH_P(VSW),
        .VINT_LINE_P(VIL)
    ) dut (
        .CLK_6M (clk),
        .RST_N  (rst_n),
        .vid    (vif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected output word for a frame position, straight from the raster rules.
    function automatic logic [25:0] expect_at(input int p);
        int h, v;
        h = p % HT;
        v = p / HT;
        return {h[8:0], v[8:0],
                1'(((h / 2) % 2) == 1),
                1'((h % 8) == 3),
                1'((h % 8) == 7),
                1'(h >= HV),
                1'(v >= VV),
                1'(h >= HSS && h < HSS + HSW),
                1'(v >= VSS && v < VSS + VSW),
                1'(h == 0 && v == VIL)};
    endfunction

    function automatic logic [25:0] actual();
        return {vif.H, vif.V, vif.CLK_2H, vif.LATCH0, vif.LATCH1, vif.HBLANK,
                vif.VBLANK, vif.HSYNC, vif.VSYNC, vif.VINT};
    endfunction

    // Model: reset returns to frame start, otherwise one position per cycle.
    always @(posedge clk) begin
        if (!rst_n) pos <= 0;
        else        pos <= (pos + 1) % FRAME;
    end

    // Every-cycle comparison of the whole output bundle against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [25:0] a, e;
            a = actual();
            e = expect_at(pos);
            n_chk++;
            if (a == e) n_pass++;
            else $display("FAIL cycle pos=%0d: got %h expected %h", pos, a, e);
        end
    end

    task automatic wait_for(input int h, input int v, input int budget);
        int n = 0;
        while (!(int'(vif.H) == h && int'(vif.V) == v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("reach_%0d_%0d", h, v), int'(n < budget), 1);
    endtask

    initial begin
        int c0, c1, c2, bad, vs, vi, vi_pos, hline, bad_lines, n;

        // Reset held for 5 edges; bundle must read all zero.
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_zero", int'(actual()), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_h1", int'(vif.H), 1);
        @(negedge clk);
        check("rel_h2", int'(vif.H), 2);

        // Line wrap at V=10.
        wait_for(383, 10, 2 * FRAME);
        check("hblank_before_wrap", int'(vif.HBLANK), 1);
        @(negedge clk);
        check("wrap_h", int'(vif.H), 0);
        check("wrap_v", int'(vif.V), 11);
        check("wrap_hblank", int'(vif.HBLANK), 0);

        // Strobes over line 11.
        c0 = 0; c1 = 0; c2 = 0; bad = 0;
        for (int i = 0; i < HT; i++) begin
            c0 += int'(vif.LATCH0);
            c1 += int'(vif.LATCH1);
            c2 += int'(vif.CLK_2H);
            if (vif.LATCH0 && (vif.H % 8) != 3) bad++;
            if (vif.LATCH1 && (vif.H % 8) != 7) bad++;
            @(negedge clk);
        end
        check("latch0_count", c0, 48);
        check("latch1_count", c1, 48);
        check("clk2h_high", c2, 192);
        check("latch_phase", bad, 0);

        // Frame wrap.
        wait_for(383, VT - 1, 2 * FRAME);
        check("vblank_before_fwrap", int'(vif.VBLANK), 1);
        @(negedge clk);
        check("fwrap_h", int'(vif.H), 0);
        check("fwrap_v", int'(vif.V), 0);
        check("fwrap_vblank", int'(vif.VBLANK), 0);
        check("fwrap_vint", int'(vif.VINT), 0);

        // Sync and interrupt over one full frame starting at (0,0).
        vs = 0; vi = 0; vi_pos = -1; hline = 0; bad_lines = 0;
        for (int i = 0; i < FRAME; i++) begin
            hline += int'(vif.HSYNC);
            vs += int'(vif.VSYNC);
            if (vif.VINT) begin
                vi++;
                vi_pos = int'(vif.V) * HT + int'(vif.H);
            end
            if (vif.H == 9'(HT - 1)) begin
                if (hline != HSW) bad_lines++;
                hline = 0;
            end
            @(negedge clk);
        end
        check("hsync_lines", bad_lines, 0);
        check("vsync_cycles", vs, VSW * HT);
        check("vint_count", vi, 1);
        check("vint_pos", vi_pos, VIL * HT);

        // Random reset pulses at random points; model follows each one.
        repeat (6) begin
            repeat ($urandom_range(1, 1500)) @(negedge clk);
            rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rst_n = 1'b1;
        end

        // Mid-frame reset at (150,10), then measure the restart-to-restart period.
        wait_for(150, 10, 2 * FRAME);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_zero", int'(actual()), 0);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(vif.H == 9'd0 && vif.V == 9'd0) && n < FRAME + 10);
        check("frame_period", n, FRAME);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
